qcm_master_controller_main: RTL and testbench

Top-level tuning controller for the QCM antenna matching network. It measures the frequency of the RF reference `sig` by counting `clk` cycles over a fixed number of `sig` periods. It maps the result to two 7-bit capacitor-bank codes, one for the series bank and one for the parallel bank, each with an enable. It also drives the board watchdog/power-enable pins.

---
 rtl/qcm_master_controller_main.sv | 152 +++++++++++++++
 tb/tb_qcm_master_controller_main.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qcm_master_controller_main.sv
// qcm_master_controller_main
//
// Tuning controller for the QCM antenna matching network. It measures the RF
// reference frequency by counting clk cycles over M periods of sig. The count is
// mapped to a series/parallel capacitor-bank code pair with enables. The block
// also drives the board power-enable and watchdog heartbeat pins.
//
// Ports:
//   clk            system clock (nominal 4 MHz)
//   reset          synchronous, active-high reset
//   sig            asynchronous RF reference square wave
//   codeSer[6:0]   series capacitor bank code
//   codePar[6:0]   parallel capacitor bank code
//   enableSer      series bank enable
//   enablePar      parallel bank enable
//   ioPowerEnable  board I/O power enable, rises WD_DELAY cycles after reset
//   clkEnable      watchdog heartbeat, toggles every WD_HALF cycles once powered
module qcm_master_controller_main #(
  parameter int unsigned M         = 50,
  parameter int unsigned NMIN      = 667,
  parameter int unsigned NMAX      = 4000,
  parameter int unsigned IDX_SHIFT = 5,
  parameter int unsigned NTIMEOUT  = 8000,
  parameter int unsigned WD_DELAY  = 16,
  parameter int unsigned WD_HALF   = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sig,
  output logic [6:0] codeSer,
  output logic [6:0] codePar,
  output logic       enableSer,
  output logic       enablePar,
  output logic       ioPowerEnable,
  output logic       clkEnable
);

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  state_e      state;
  logic [15:0] n;
  logic [15:0] edge_cnt;
  logic [15:0] wd_cnt;
  logic [15:0] hb_cnt;

  logic        sig_meta;
  logic        sig_sync;
  logic        sig_prev;
  logic        sedge;

  logic [15:0] n_off;
  logic [15:0] n_shift;
  logic [6:0]  idx;
  logic        in_band;
  logic        timeout;
  logic        last_edge;

  // The synchronizer is left out of reset so a sig that is already high when
  // reset releases is not mistaken for a rising edge.
  always_ff @(posedge clk) begin
    sig_meta <= sig;
    sig_sync <= sig_meta;
    sig_prev <= sig_sync;
  end

  assign sedge = sig_sync & ~sig_prev;

  always_comb begin
    n_off     = n - 16'(NMIN);
    n_shift   = n_off >> IDX_SHIFT;
    idx       = (n_shift > 16'd127) ? 7'd127 : n_shift[6:0];
    in_band   = (n >= 16'(NMIN)) && (n <= 16'(NMAX));
    timeout   = (n == 16'(NTIMEOUT));
    last_edge = sedge && (edge_cnt == 16'(M - 1));
  end

  // Window FSM. n holds the cycles elapsed since the window-start edge, so on
  // the M-th edge it equals exactly M sig periods. Timeout wins over an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      n         <= 16'd0;
      edge_cnt  <= 16'd0;
      codeSer   <= 7'd0;
      codePar   <= 7'd0;
      enableSer <= 1'b0;
      enablePar <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (sedge) begin
            n        <= 16'd1;
            edge_cnt <= 16'd0;
            state    <= StCount;
          end
        end
        StCount: begin
          if (timeout) begin
            enableSer <= 1'b0;
            enablePar <= 1'b0;
            n         <= 16'd0;
            edge_cnt  <= 16'd0;
            state     <= StIdle;
          end else if (last_edge) begin
            // Next window starts on this same edge, so no edge is lost.
            n        <= 16'd1;
            edge_cnt <= 16'd0;
            if (in_band) begin
              codeSer   <= idx;
              codePar   <= 7'd127 - idx;
              enableSer <= 1'b1;
              enablePar <= 1'b1;
            end else begin
              enableSer <= 1'b0;
              enablePar <= 1'b0;
            end
          end else begin
            if (n != 16'hffff) begin
              n <= n + 16'd1;
            end
            if (sedge) begin
              edge_cnt <= edge_cnt + 16'd1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Power enable after a fixed delay, then a free-running heartbeat.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt        <= 16'd0;
      hb_cnt        <= 16'd0;
      ioPowerEnable <= 1'b0;
      clkEnable     <= 1'b0;
    end else if (!ioPowerEnable) begin
      if (wd_cnt == 16'(WD_DELAY - 1)) begin
        ioPowerEnable <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 16'd1;
      end
    end else if (hb_cnt == 16'(WD_HALF - 1)) begin
      hb_cnt    <= 16'd0;
      clkEnable <= ~clkEnable;
    end else begin
      hb_cnt <= hb_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_qcm_master_controller_main.sv
// Bench for qcm_master_controller_main. sig is generated as a square wave of a
// chosen integer period in clk cycles. A reference model built from edge
// timestamps predicts the outputs every cycle; each scenario adds spot checks
// against values worked out by hand from the frequency/code mapping.
module tb_qcm_master_controller_main;

  localparam int M         = 50;
  localparam int NMIN      = 667;
  localparam int NMAX      = 4000;
  localparam int IDX_SHIFT = 5;
  localparam int NTIMEOUT  = 8000;
  localparam int WD_DELAY  = 16;
  localparam int WD_HALF   = 1000;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       sig   = 1'b0;
  logic [6:0] codeSer;
  logic [6:0] codePar;
  logic       enableSer;
  logic       enablePar;
  logic       ioPowerEnable;
  logic       clkEnable;

  qcm_master_controller_main #(
    .M(M), .NMIN(NMIN), .NMAX(NMAX), .IDX_SHIFT(IDX_SHIFT),
    .NTIMEOUT(NTIMEOUT), .WD_DELAY(WD_DELAY), .WD_HALF(WD_HALF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sig(sig),
    .codeSer(codeSer),
    .codePar(codePar),
    .enableSer(enableSer),
    .enablePar(enablePar),
    .ioPowerEnable(ioPowerEnable),
    .clkEnable(clkEnable)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ph     = 0;

  // Last four sig values driven; a rising edge reaches the FSM three clocks later.
  bit sq[$] = '{1'b0, 1'b0, 1'b0, 1'b0};

  // Reference model state.
  bit         m_idle = 1'b1;
  int         win[$];
  int         wd = 0;
  logic [6:0] e_ser = 7'd0;
  logic [6:0] e_par = 7'd0;
  bit         e_en  = 1'b0;

  // One clock: update model for this edge, compare, then drive the next sig value.
  task automatic step(input int period);
    bit   ev;
    int   n;
    int   idx;
    bit   e_pwr;
    bit   e_ck;
    @(posedge clk);
    cyc++;
    ev = sq[1] && !sq[0];
    if (reset) begin
      m_idle = 1'b1;
      win.delete();
      e_ser = 7'd0;
      e_par = 7'd0;
      e_en  = 1'b0;
      wd    = 0;
    end else begin
      wd++;
      if (!m_idle && (cyc - win[0] == NTIMEOUT)) begin
        e_en   = 1'b0;
        m_idle = 1'b1;
        win.delete();
      end else if (ev) begin
        win.push_back(cyc);
        m_idle = 1'b0;
        if (win.size() == M + 1) begin
          n = win[M] - win[0];
          if (n >= NMIN && n <= NMAX) begin
            idx = (n - NMIN) >> IDX_SHIFT;
            if (idx > 127) idx = 127;
            e_ser = 7'(idx);
            e_par = 7'(127 - idx);
            e_en  = 1'b1;
          end else begin
            e_en = 1'b0;
          end
          win.delete();
          win.push_back(cyc);
        end
      end
    end
    e_pwr = (wd >= WD_DELAY);
    e_ck  = e_pwr ? (((wd - WD_DELAY) / WD_HALF) % 2 == 1) : 1'b0;
    #1;
    checks++;
    if ({codeSer, codePar, enableSer, enablePar} !== {e_ser, e_par, e_en, e_en}) begin
      errors++;
      $display("FAIL bank cycle %0d: ser=%0d par=%0d en=%b%b, expected ser=%0d par=%0d en=%b",
               cyc, codeSer, codePar, enableSer, enablePar, e_ser, e_par, e_en);
    end
    checks++;
    if ({ioPowerEnable, clkEnable} !== {e_pwr, e_ck}) begin
      errors++;
      $display("FAIL watchdog cycle %0d: pwr=%b ck=%b, expected pwr=%b ck=%b",
               cyc, ioPowerEnable, clkEnable, e_pwr, e_ck);
    end
    if (period == 0) begin
      sig = 1'b0;
    end else begin
      sig = (ph < period / 2);
      ph  = (ph + 1) % period;
    end
    sq.push_back(sig);
    void'(sq.pop_front());
  endtask

  task automatic run(input int period, input int cycles);
    for (int i = 0; i < cycles; i++) step(period);
  endtask

  task automatic spot_bank(input string name, input int ser, input int par, input bit en);
    checks++;
    if ({codeSer, codePar, enableSer, enablePar} !== {7'(ser), 7'(par), en, en}) begin
      errors++;
      $display("FAIL %s: ser=%0d par=%0d en=%b%b, expected ser=%0d par=%0d en=%b",
               name, codeSer, codePar, enableSer, enablePar, ser, par, en);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    run(0, 5);
    checks++;
    if ({codeSer, codePar, enableSer, enablePar, ioPowerEnable, clkEnable} !== 18'd0) begin
      errors++;
      $display("FAIL reset_state: outputs=%h, expected 0",
               {codeSer, codePar, enableSer, enablePar, ioPowerEnable, clkEnable});
    end
    reset = 1'b0;
    run(0, WD_DELAY - 1);
    checks++;
    if (ioPowerEnable !== 1'b0) begin
      errors++;
      $display("FAIL power_early: ioPowerEnable=%b, expected 0", ioPowerEnable);
    end
    run(0, 1);
    checks++;
    if (ioPowerEnable !== 1'b1) begin
      errors++;
      $display("FAIL power_rise: ioPowerEnable=%b, expected 1", ioPowerEnable);
    end
  endtask

  task automatic test_watchdog();
    run(0, WD_HALF - 1);
    checks++;
    if (clkEnable !== 1'b0) begin
      errors++;
      $display("FAIL heartbeat_pre: clkEnable=%b, expected 0", clkEnable);
    end
    run(0, 1);
    checks++;
    if (clkEnable !== 1'b1) begin
      errors++;
      $display("FAIL heartbeat_toggle1: clkEnable=%b, expected 1", clkEnable);
    end
    run(0, WD_HALF);
    checks++;
    if (clkEnable !== 1'b0) begin
      errors++;
      $display("FAIL heartbeat_toggle2: clkEnable=%b, expected 0", clkEnable);
    end
  endtask

  task automatic test_out_of_band();
    ph = 0;
    run(10, 1100);
    spot_bank("out_of_band_400k", 0, 0, 1'b0);
  endtask

  task automatic test_in_band();
    ph = 0;
    run(50, 5200);
    spot_bank("in_band_80k", 57, 70, 1'b1);
  endtask

  task automatic test_follow();
    ph = 0;
    run(23, 3600);
    spot_bank("in_band_174k", 15, 112, 1'b1);
  endtask

  task automatic test_timeout();
    ph = 0;
    run(10000, 9000);
    spot_bank("timeout_400hz", int'(e_ser), int'(e_par), 1'b0);
    checks++;
    if (enableSer !== 1'b0 || enablePar !== 1'b0) begin
      errors++;
      $display("FAIL timeout_enables: en=%b%b, expected 00", enableSer, enablePar);
    end
  endtask

  task automatic test_reset_mid_window();
    ph = 0;
    run(50, 3000);
    reset = 1'b1;
    run(50, 5);
    checks++;
    if ({codeSer, codePar, enableSer, enablePar, ioPowerEnable, clkEnable} !== 18'd0) begin
      errors++;
      $display("FAIL mid_reset_state: outputs=%h, expected 0",
               {codeSer, codePar, enableSer, enablePar, ioPowerEnable, clkEnable});
    end
    reset = 1'b0;
    run(50, 2500);
    spot_bank("mid_reset_no_early_update", 0, 0, 1'b0);
    run(50, 150);
    spot_bank("mid_reset_first_update", 57, 70, 1'b1);
  endtask

  // 50 periods of 160 cycles lands the M-th edge exactly on the timeout count.
  task automatic test_tie();
    ph = 0;
    run(160, 16600);
    checks++;
    if (enableSer !== 1'b0 || enablePar !== 1'b0) begin
      errors++;
      $display("FAIL tie_timeout: en=%b%b, expected 00", enableSer, enablePar);
    end
  endtask

  task automatic test_random();
    int p;
    int n;
    int idx;
    for (int k = 0; k < 3; k++) begin
      p  = $urandom_range(90, 12);
      ph = 0;
      run(p, 8060 + M * p);
      n = M * p;
      if (n >= NMIN && n <= NMAX) begin
        idx = (n - NMIN) / 32;
        if (idx > 127) idx = 127;
        spot_bank($sformatf("random_p%0d", p), idx, 127 - idx, 1'b1);
      end else begin
        checks++;
        if (enableSer !== 1'b0 || enablePar !== 1'b0) begin
          errors++;
          $display("FAIL random_p%0d_oob: en=%b%b, expected 00", p, enableSer, enablePar);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_watchdog();
    test_out_of_band();
    test_in_band();
    test_follow();
    test_timeout();
    test_reset_mid_window();
    test_tie();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
